// File: rtl/ex_wb_stage.sv
// EX→WB pipeline register with the HI/LO registers, WB data select,
// GPIO output register and gpio_in synchronizer.
module ex_wb_stage #(
    parameter int DW          = 32,
    parameter int AW          = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid_EX,
    input  logic          regwrite_EX,
    input  logic          rdrt_EX,
    input  logic [AW-1:0] rd_EX,
    input  logic [AW-1:0] rt_EX,
    input  logic [1:0]    regsel_EX,
    input  logic          enhilo_EX,
    input  logic          GPIO_OUT,
    input  logic          GPIO_IN,
    input  logic [DW-1:0] lo_EX,
    input  logic [DW-1:0] hi_EX,
    input  logic [DW-1:0] readdata2_EX,
    input  logic [DW-1:0] gpio_in,
    output logic [DW-1:0] gpio_out,
    output logic          regwrite_WB,
    output logic [AW-1:0] writeaddr_WB,
    output logic [DW-1:0] writedata_WB,
    output logic [DW-1:0] hi_q,
    output logic [DW-1:0] lo_q
);

    logic [SYNC_STAGES-1:0][DW-1:0] sync_q;
    logic [DW-1:0]                  gpio_sync;
    logic [AW-1:0]                  dest;
    logic                           wr_en;
    logic [DW-1:0]                  wdata;

    assign gpio_sync = sync_q[SYNC_STAGES-1];

    // Free-running chain; stage 0 is the metastability-catching flop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], gpio_in};
        end
    end

    assign dest  = rdrt_EX ? rt_EX : rd_EX;
    assign wr_en = valid_EX & regwrite_EX & ~GPIO_OUT & (dest != '0);

    always_comb begin
        wdata = lo_EX;
        if (GPIO_IN) begin
            wdata = gpio_sync;
        end else if (regsel_EX == 2'd1) begin
            wdata = hi_q;
        end else if (regsel_EX == 2'd2) begin
            wdata = lo_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regwrite_WB  <= 1'b0;
            writeaddr_WB <= '0;
            writedata_WB <= '0;
        end else begin
            regwrite_WB <= wr_en;
            if (valid_EX) begin
                writeaddr_WB <= dest;
                writedata_WB <= wdata;
            end
        end
    end

    // mfhi/mflo one cycle after mult sees the new value via this register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (valid_EX && enhilo_EX) begin
            hi_q <= hi_EX;
            lo_q <= lo_EX;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gpio_out <= '0;
        end else if (valid_EX && GPIO_OUT) begin
            gpio_out <= readdata2_EX;
        end
    end

endmodule

// File: tb/tb_ex_wb_stage.sv
// Self-checking bench for ex_wb_stage: directed plan steps, then random
// traffic against a behavioural model of the WB stage.
module tb_ex_wb_stage;

    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int SYNC = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_EX, regwrite_EX, rdrt_EX;
    logic [AW-1:0] rd_EX, rt_EX;
    logic [1:0]    regsel_EX;
    logic          enhilo_EX, GPIO_OUT, GPIO_IN;
    logic [DW-1:0] lo_EX, hi_EX, readdata2_EX, gpio_in;
    logic [DW-1:0] gpio_out;
    logic          regwrite_WB;
    logic [AW-1:0] writeaddr_WB;
    logic [DW-1:0] writedata_WB, hi_q, lo_q;

    int n_asserts = 0;
    int n_fail    = 0;

    // model state
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data, m_hi, m_lo, m_gpo;
    logic [DW-1:0] hist[$];

    always #5 clk = ~clk;

    ex_wb_stage #(.DW(DW), .AW(AW), .SYNC_STAGES(SYNC)) dut (
        .clk         (clk),
        .rst         (rst),
        .valid_EX    (valid_EX),
        .regwrite_EX (regwrite_EX),
        .rdrt_EX     (rdrt_EX),
        .rd_EX       (rd_EX),
        .rt_EX       (rt_EX),
        .regsel_EX   (regsel_EX),
        .enhilo_EX   (enhilo_EX),
        .GPIO_OUT    (GPIO_OUT),
        .GPIO_IN     (GPIO_IN),
        .lo_EX       (lo_EX),
        .hi_EX       (hi_EX),
        .readdata2_EX(readdata2_EX),
        .gpio_in     (gpio_in),
        .gpio_out    (gpio_out),
        .regwrite_WB (regwrite_WB),
        .writeaddr_WB(writeaddr_WB),
        .writedata_WB(writedata_WB),
        .hi_q        (hi_q),
        .lo_q        (lo_q)
    );

    task automatic chk(input string tag, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
        n_asserts++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_we   = 1'b0;
        m_addr = '0;
        m_data = '0;
        m_hi   = '0;
        m_lo   = '0;
        m_gpo  = '0;
        hist   = {};
        repeat (SYNC) hist.push_back('0);
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".we"},   {31'b0, regwrite_WB}, {31'b0, m_we});
        chk({tag, ".addr"}, {27'b0, writeaddr_WB}, {27'b0, m_addr});
        chk({tag, ".data"}, writedata_WB, m_data);
        chk({tag, ".hi"},   hi_q, m_hi);
        chk({tag, ".lo"},   lo_q, m_lo);
        chk({tag, ".gpo"},  gpio_out, m_gpo);
    endtask

    // One clock: advance the model using the pre-edge inputs, then check.
    task automatic cyc(input string tag);
        logic [AW-1:0] d;
        logic [DW-1:0] synced;
        if (rst) begin
            d      = rdrt_EX ? rt_EX : rd_EX;
            synced = hist[0];
            if (valid_EX) begin
                m_we   = regwrite_EX && !GPIO_OUT && (d != 0);
                m_addr = d;
                if (GPIO_IN)             m_data = synced;
                else if (regsel_EX == 1) m_data = m_hi;
                else if (regsel_EX == 2) m_data = m_lo;
                else                     m_data = lo_EX;
                if (enhilo_EX) begin
                    m_hi = hi_EX;
                    m_lo = lo_EX;
                end
                if (GPIO_OUT) m_gpo = readdata2_EX;
            end else begin
                m_we = 1'b0;
            end
            hist.push_back(gpio_in);
            void'(hist.pop_front());
        end
        @(posedge clk);
        #1;
        chk_all(tag);
    endtask

    task automatic idle();
        valid_EX = 0; regwrite_EX = 0; rdrt_EX = 0;
        rd_EX = 0; rt_EX = 0; regsel_EX = 0;
        enhilo_EX = 0; GPIO_OUT = 0; GPIO_IN = 0;
        lo_EX = 0; hi_EX = 0; readdata2_EX = 0;
    endtask

    task automatic rnd_inputs();
        valid_EX     = ($urandom_range(0, 3) != 0);
        regwrite_EX  = $urandom_range(0, 1);
        rdrt_EX      = $urandom_range(0, 1);
        rd_EX        = ($urandom_range(0, 7) == 0) ? 5'd0 : AW'($urandom);
        rt_EX        = ($urandom_range(0, 7) == 0) ? 5'd0 : AW'($urandom);
        regsel_EX    = 2'($urandom);
        enhilo_EX    = ($urandom_range(0, 3) == 0);
        GPIO_OUT     = ($urandom_range(0, 7) == 0);
        GPIO_IN      = ($urandom_range(0, 5) == 0);
        lo_EX        = $urandom;
        hi_EX        = $urandom;
        readdata2_EX = $urandom;
        gpio_in      = $urandom;
    endtask

    initial begin
        gpio_in = 0;
        idle();
        model_clear();

        // held in reset with random inputs
        rst = 1'b0;
        #1;
        chk_all("reset0");
        repeat (3) begin
            rnd_inputs();
            cyc("reset_hold");
        end
        @(negedge clk);
        rst = 1'b1;
        idle();
        gpio_in = 0;
        cyc("post_release");

        // add $5
        valid_EX = 1; regwrite_EX = 1; rd_EX = 5; lo_EX = 32'h7;
        cyc("add");
        chk("add.we", {31'b0, regwrite_WB}, 32'h1);
        chk("add.addr", {27'b0, writeaddr_WB}, 32'h5);
        chk("add.data", writedata_WB, 32'h7);

        // mult then mfhi, mflo
        idle();
        valid_EX = 1; enhilo_EX = 1; hi_EX = 32'h1; lo_EX = 32'hFFFF_FFFE;
        cyc("mult");
        chk("mult.we", {31'b0, regwrite_WB}, 32'h0);
        idle();
        valid_EX = 1; regwrite_EX = 1; regsel_EX = 1; rd_EX = 3;
        lo_EX = $urandom;
        cyc("mfhi");
        chk("mfhi.data", writedata_WB, 32'h1);
        chk("mfhi.addr", {27'b0, writeaddr_WB}, 32'h3);
        regsel_EX = 2; rd_EX = 4; lo_EX = $urandom;
        cyc("mflo");
        chk("mflo.data", writedata_WB, 32'hFFFF_FFFE);
        chk("mflo.we", {31'b0, regwrite_WB}, 32'h1);

        // $0 and rt destination
        idle();
        valid_EX = 1; regwrite_EX = 1; rdrt_EX = 1; rt_EX = 0; rd_EX = 7;
        lo_EX = 32'h55;
        cyc("addi_r0");
        chk("addi_r0.we", {31'b0, regwrite_WB}, 32'h0);
        rt_EX = 9; rd_EX = 2;
        cyc("addi_rt");
        chk("addi_rt.addr", {27'b0, writeaddr_WB}, 32'h9);

        // GPIO in via synchronizer, then GPIO out
        idle();
        gpio_in = 32'hA5A5_A5A5;
        cyc("sync1");
        cyc("sync2");
        valid_EX = 1; regwrite_EX = 1; GPIO_IN = 1; rd_EX = 6;
        lo_EX = $urandom;
        cyc("gpio_in");
        chk("gpio_in.data", writedata_WB, 32'hA5A5_A5A5);
        chk("gpio_in.addr", {27'b0, writeaddr_WB}, 32'h6);
        idle();
        valid_EX = 1; regwrite_EX = 1; GPIO_OUT = 1; rd_EX = 8;
        readdata2_EX = 32'h1234;
        cyc("gpio_out");
        chk("gpio_out.val", gpio_out, 32'h1234);
        chk("gpio_out.we", {31'b0, regwrite_WB}, 32'h0);

        // bubble must not touch any state
        valid_EX = 0; regwrite_EX = 1; enhilo_EX = 1; GPIO_OUT = 1;
        hi_EX = $urandom; lo_EX = $urandom; readdata2_EX = $urandom;
        cyc("bubble");
        chk("bubble.gpo", gpio_out, 32'h1234);
        chk("bubble.hi", hi_q, 32'h1);

        // X on lo_EX with no write must not leak into state
        idle();
        valid_EX = 1; GPIO_OUT = 1; readdata2_EX = 32'h1234;
        lo_EX = 'x;
        cyc("x_lo");
        chk("x_lo.lo", lo_q, 32'hFFFF_FFFE);

        // async reset mid-stream
        idle();
        valid_EX = 1; regwrite_EX = 1; rd_EX = 11; lo_EX = 32'hBEEF;
        cyc("pre_rst");
        chk("pre_rst.we", {31'b0, regwrite_WB}, 32'h1);
        #2;
        rst = 1'b0;
        #1;
        model_clear();
        chk_all("async_rst");
        chk("async_rst.gpo", gpio_out, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        valid_EX = 1; regwrite_EX = 1; rd_EX = 12; lo_EX = 32'hCAFE;
        cyc("post_rst_add");
        chk("post_rst_add.data", writedata_WB, 32'hCAFE);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            rnd_inputs();
            cyc("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_wb_stage.md
Name: ex_wb_stage

Overview:
- Pipeline stage directly downstream of the control unit's EX outputs.
- Registers EX results into WB and owns the architectural HI/LO registers.
- Selects the register-file write data from ALU lo, HI, LO or GPIO-in, and owns the GPIO-out register.
- Drives the register-file write port (address, data, enable) in the WB cycle.

Parameters:
- DW, 32, datapath width (ALU results, HI/LO, GPIO).
- AW, 5, register-file address width.
- SYNC_STAGES, 2, flop stages in the gpio_in synchronizer (legal values 2..3).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset: asynchronous, active-low. Asserting (0) clears all state immediately; release is synchronous to clk.
- valid_EX  in  1  EX holds a real instruction; 0 means bubble or stall.
- regwrite_EX  in  1  from control unit.
- rdrt_EX  in  1  destination select: 0 = rd, 1 = rt.
- rd_EX  in  AW  instruction_EX[15:11].
- rt_EX  in  AW  instruction_EX[20:16].
- regsel_EX  in  2  0 = ALU lo, 1 = HI (mfhi), 2 = LO (mflo), 3 = treated as 0.
- enhilo_EX  in  1  mult/multu: load HI/LO.
- GPIO_OUT  in  1  GPIO write enable (srl, shamt 0).
- GPIO_IN  in  1  GPIO read enable (sra, shamt 0).
- lo_EX  in  DW  ALU low result.
- hi_EX  in  DW  ALU high result.
- readdata2_EX  in  DW  rt operand; the GPIO write source.
- gpio_in  in  DW  asynchronous external input.
- gpio_out  out  DW  registered GPIO output.
- regwrite_WB  out  1  register-file write enable.
- writeaddr_WB  out  AW  register-file write address.
- writedata_WB  out  DW  register-file write data.
- hi_q  out  DW  current HI (debug/visibility).
- lo_q  out  DW  current LO (debug/visibility).

Behaviour:
- Reset (rst = 0, asynchronous): all of the following clear to 0: regwrite_WB, writeaddr_WB, writedata_WB, gpio_out, hi_q, lo_q, and every synchronizer flop.
- Reset during operation: any in-flight WB write is dropped (regwrite_WB = 0 immediately). The first edge after release captures EX normally.
- Latency, EX to WB: one clock. Values presented in EX cycle n appear on the *_WB outputs during cycle n+1.
- Bubble: valid_EX = 0 at the edge gives regwrite_WB <= 0. writeaddr_WB and writedata_WB hold their previous values. HI, LO and gpio_out do not change.
- Destination: dest = rdrt_EX ? rt_EX : rd_EX.
- Write enable: regwrite_WB <= valid_EX & regwrite_EX & ~GPIO_OUT & (dest != 0).
  - GPIO writes never touch the register file, even though the control unit asserts regwrite for them.
  - Writes to $0 are suppressed.
- Data select, evaluated in EX and registered, in priority order:
  1. GPIO_IN: synchronized gpio_in (output of the last synchronizer stage).
  2. regsel_EX = 1: hi_q.
  3. regsel_EX = 2: lo_q.
  4. Otherwise: lo_EX.
- HI/LO update: at the edge, if valid_EX & enhilo_EX then hi_q <= hi_EX and lo_q <= lo_EX.
- Back-to-back mult/mfhi: mult in EX cycle n, then mfhi/mflo in EX cycle n+1, reads the updated value. No forwarding is needed and no stall is required.
- mfhi/mflo in the same EX cycle as enhilo: not possible, since they are distinct instructions.
- GPIO write: at the edge, if valid_EX & GPIO_OUT then gpio_out <= readdata2_EX. gpio_out holds that value until the next GPIO write or reset.
- GPIO_IN and GPIO_OUT both asserted (illegal decode): both actions occur.
  - gpio_out loads readdata2_EX.
  - writedata_WB gets the synchronized input.
  - regwrite_WB = 0, because GPIO_OUT suppresses the write.
- gpio_in synchronizer:
  - SYNC_STAGES-flop chain, clocked every cycle regardless of valid_EX.
  - A change on gpio_in becomes readable by a GPIO_IN instruction whose EX edge is SYNC_STAGES edges after the change.
- X inputs: alu_op/shamt X from the control unit never reaches this block. If lo_EX is X on a cycle where regwrite_WB evaluates to 0, it must not propagate to gpio_out, hi_q or lo_q.
- Combinational paths: none from any input to any output; all outputs are flop outputs.

Test Plan:
- Reset and write path: hold rst = 0 with random inputs → all outputs 0. Release, then add with rd = 5, lo_EX = 0x0000_0007, valid = 1 → next cycle regwrite_WB = 1, writeaddr_WB = 5, writedata_WB = 7.
- Mult then mfhi/mflo: mult with hi_EX = 0x1, lo_EX = 0xFFFF_FFFE. Next cycle mfhi (regsel = 1, rd = 3), then mflo (regsel = 2, rd = 4) → WB writes 0x1 to $3, then 0xFFFF_FFFE to $4. The mult itself produces regwrite_WB = 0.
- Register $0 and immediate destination:
  - addi with rdrt = 1, rt = 0 → regwrite_WB = 0.
  - addi with rt = 9, rd = 2 → writeaddr_WB = 9.
- GPIO: set gpio_in = 0xA5A5_A5A5 and wait 2 edges, then issue GPIO_IN with rd = 6 → writedata_WB = 0xA5A5_A5A5 to $6. Issue GPIO_OUT with readdata2 = 0x1234 → gpio_out = 0x1234 next cycle and regwrite_WB = 0.
- Bubble/stall: valid_EX = 0 while enhilo = 1, GPIO_OUT = 1, regwrite = 1 → hi_q, lo_q and gpio_out unchanged, regwrite_WB = 0.
- Async reset mid-stream: assert rst between edges while regwrite_WB = 1 and gpio_out = 0x1234 → both clear without waiting for a clock edge. After release, the next valid add is written normally.
